vga_timing_mode: RTL and testbench

//  Parametrised VGA timing generator with two runtime-selectable video modes.

---
 rtl/vga_mode_pkg.sv | 44 ++++
 rtl/vga_timing_mode.sv | 111 +++++++++++
 tb/tb_vga_timing_mode.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_mode_pkg.sv
// Timing sets for the runtime-selectable VGA modes; each field is in pixel or line units.
// Sync windows are inclusive on both ends, and the polarity bit gives the active sync level.
package vga_mode_pkg;

    typedef struct packed {
        logic [10:0] h_active;
        logic [10:0] h_sync_start;
        logic [10:0] h_sync_end;
        logic [10:0] h_total;
        logic [10:0] v_active;
        logic [10:0] v_sync_start;
        logic [10:0] v_sync_end;
        logic [10:0] v_total;
        logic        h_pol;
        logic        v_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_800X600 = '{
        h_active:     11'd800,
        h_sync_start: 11'd840,
        h_sync_end:   11'd967,
        h_total:      11'd1056,
        v_active:     11'd600,
        v_sync_start: 11'd601,
        v_sync_end:   11'd604,
        v_total:      11'd628,
        h_pol:        1'b1,
        v_pol:        1'b1
    };

    localparam vga_mode_t MODE_640X480 = '{
        h_active:     11'd640,
        h_sync_start: 11'd656,
        h_sync_end:   11'd751,
        h_total:      11'd800,
        v_active:     11'd480,
        v_sync_start: 11'd490,
        v_sync_end:   11'd491,
        v_total:      11'd525,
        h_pol:        1'b0,
        v_pol:        1'b0
    };

endpackage

// File: rtl/vga_timing_mode.sv
// Two-mode VGA timing generator; every output is registered and describes the pixel at hcount/vcount.
// A mode request is latched only on the end-of-frame cycle, so a frame is always generated in a single mode.
module vga_timing_mode
    import vga_mode_pkg::*;
#(
    parameter vga_mode_t MODE_A      = MODE_800X600,
    parameter vga_mode_t MODE_B      = MODE_640X480,
    parameter int        CNT_W       = 11,
    parameter int        FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   mode_sel,
    output logic                   mode_active,
    output logic [CNT_W-1:0]       hcount,
    output logic [CNT_W-1:0]       vcount,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   hblnk,
    output logic                   vblnk,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    vga_mode_t              r_mode;
    logic                   r_mode_active;
    logic [CNT_W-1:0]       r_hcount;
    logic [CNT_W-1:0]       r_vcount;
    logic                   r_hsync;
    logic                   r_vsync;
    logic                   r_hblnk;
    logic                   r_vblnk;
    logic                   r_frame_start;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic                   w_h_last;
    logic                   w_v_last;
    logic                   w_eof;
    logic                   w_mode_active_nxt;
    vga_mode_t              w_mode_nxt;
    logic [CNT_W-1:0]       w_hcount_nxt;
    logic [CNT_W-1:0]       w_vcount_nxt;
    logic                   w_hsync_nxt;
    logic                   w_vsync_nxt;
    logic                   w_hblnk_nxt;
    logic                   w_vblnk_nxt;

    always_comb begin
        w_h_last          = (r_hcount == CNT_W'(r_mode.h_total - 11'd1));
        w_v_last          = (r_vcount == CNT_W'(r_mode.v_total - 11'd1));
        w_eof             = w_h_last && w_v_last;
        w_mode_active_nxt = w_eof ? mode_sel : r_mode_active;
        // Decode uses the mode of the next pixel, so (0,0) after a switch already carries the new timing.
        w_mode_nxt        = w_mode_active_nxt ? MODE_B : MODE_A;

        w_hcount_nxt = w_h_last ? '0 : r_hcount + CNT_W'(1);
        w_vcount_nxt = r_vcount;
        if (w_h_last) begin
            w_vcount_nxt = w_v_last ? '0 : r_vcount + CNT_W'(1);
        end

        w_hsync_nxt = ((w_hcount_nxt >= CNT_W'(w_mode_nxt.h_sync_start)) &&
                       (w_hcount_nxt <= CNT_W'(w_mode_nxt.h_sync_end))) ?
                      w_mode_nxt.h_pol : ~w_mode_nxt.h_pol;
        w_vsync_nxt = ((w_vcount_nxt >= CNT_W'(w_mode_nxt.v_sync_start)) &&
                       (w_vcount_nxt <= CNT_W'(w_mode_nxt.v_sync_end))) ?
                      w_mode_nxt.v_pol : ~w_mode_nxt.v_pol;
        w_hblnk_nxt = (w_hcount_nxt >= CNT_W'(w_mode_nxt.h_active));
        w_vblnk_nxt = (w_vcount_nxt >= CNT_W'(w_mode_nxt.v_active));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode        <= MODE_A;
            r_mode_active <= 1'b0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~MODE_A.h_pol;
            r_vsync       <= ~MODE_A.v_pol;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else if (en) begin
            r_mode        <= w_mode_nxt;
            r_mode_active <= w_mode_active_nxt;
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_hblnk       <= w_hblnk_nxt;
            r_vblnk       <= w_vblnk_nxt;
            r_frame_start <= w_eof;
            if (w_eof) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    assign mode_active = r_mode_active;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_mode.sv
// Bench for vga_timing_mode: small custom modes against a pixel-index reference model,
// plus a default-parameter instance checked against closed-form 800x600 timing.
module tb_vga_timing_mode;
    import vga_mode_pkg::*;

    localparam vga_mode_t TB_MODE_A = '{
        h_active: 11'd20, h_sync_start: 11'd22, h_sync_end: 11'd25, h_total: 11'd30,
        v_active: 11'd10, v_sync_start: 11'd11, v_sync_end: 11'd13, v_total: 11'd15,
        h_pol: 1'b1, v_pol: 1'b1};
    localparam vga_mode_t TB_MODE_B = '{
        h_active: 11'd16, h_sync_start: 11'd18, h_sync_end: 11'd20, h_total: 11'd24,
        v_active: 11'd8, v_sync_start: 11'd9, v_sync_end: 11'd9, v_total: 11'd12,
        h_pol: 1'b0, v_pol: 1'b0};

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode_sel;
    logic        mode_active;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        frame_start;
    logic [1:0]  frame_cnt;

    logic        d_mode_active;
    logic [10:0] d_hcount;
    logic [10:0] d_vcount;
    logic        d_hsync;
    logic        d_vsync;
    logic        d_hblnk;
    logic        d_vblnk;
    logic        d_frame_start;
    logic [15:0] d_frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: position as a linear pixel index within the frame.
    int m_pix  = 0;
    bit m_mode = 1'b0;
    bit m_fs   = 1'b0;
    int m_fc   = 0;
    int d_n    = 0;

    vga_timing_mode #(
        .MODE_A(TB_MODE_A), .MODE_B(TB_MODE_B), .CNT_W(11), .FRAME_CNT_W(2)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel),
        .mode_active(mode_active), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    vga_timing_mode u_dut_def (
        .clk(clk), .rst(rst), .en(1'b1), .mode_sel(1'b0),
        .mode_active(d_mode_active), .hcount(d_hcount), .vcount(d_vcount),
        .hsync(d_hsync), .vsync(d_vsync), .hblnk(d_hblnk), .vblnk(d_vblnk),
        .frame_start(d_frame_start), .frame_cnt(d_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic vga_mode_t mode_of(input bit m);
        return m ? TB_MODE_B : TB_MODE_A;
    endfunction

    function automatic int frame_len(input bit m);
        vga_mode_t t = mode_of(m);
        return int'(t.h_total) * int'(t.v_total);
    endfunction

    function automatic logic [63:0] exp_vec();
        vga_mode_t t  = mode_of(m_mode);
        int        h  = m_pix % int'(t.h_total);
        int        v  = m_pix / int'(t.h_total);
        logic      hs = (h >= int'(t.h_sync_start) && h <= int'(t.h_sync_end)) ? t.h_pol : !t.h_pol;
        logic      vs = (v >= int'(t.v_sync_start) && v <= int'(t.v_sync_end)) ? t.v_pol : !t.v_pol;
        return 64'({m_mode, 11'(h), 11'(v), hs, vs, (h >= int'(t.h_active)),
                    (v >= int'(t.v_active)), m_fs, 2'(m_fc)});
    endfunction

    function automatic logic [63:0] got_vec();
        return 64'({mode_active, hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt});
    endfunction

    function automatic logic [63:0] exp_def();
        int n = d_n % (1056 * 628);
        int h = n % 1056;
        int v = n / 1056;
        return 64'({1'b0, 11'(h), 11'(v), (h >= 840 && h <= 967), (v >= 601 && v <= 604),
                    (h >= 800), (v >= 600), (d_n > 0 && n == 0), 16'(d_n / (1056 * 628))});
    endfunction

    function automatic logic [63:0] got_def();
        return 64'({d_mode_active, d_hcount, d_vcount, d_hsync, d_vsync, d_hblnk, d_vblnk,
                    d_frame_start, d_frame_cnt});
    endfunction

    // Advance the model with the inputs already applied, clock once, then compare away from the edge.
    task automatic tick();
        if (!rst) begin
            m_pix = 0; m_mode = 1'b0; m_fs = 1'b0; m_fc = 0; d_n = 0;
        end else begin
            d_n++;
            if (en) begin
                if (m_pix == frame_len(m_mode) - 1) begin
                    m_pix = 0; m_mode = mode_sel; m_fs = 1'b1; m_fc = (m_fc + 1) % 4;
                end else begin
                    m_pix++; m_fs = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_val("scoreboard", got_vec(), exp_vec());
        check_val("default_mode", got_def(), exp_def());
    endtask

    task automatic run_to_pix(input int target);
        int k = 0;
        while (m_pix != target && k < 2000) begin
            tick();
            k++;
        end
        if (m_pix != target) check_val("run_to_pix_timeout", 64'(k), 64'(0));
    endtask

    task automatic wait_fs();
        int k = 0;
        do begin
            tick();
            k++;
        end while (frame_start !== 1'b1 && k < 2000);
        if (frame_start !== 1'b1) check_val("wait_fs_timeout", 64'(frame_start), 64'(1));
    endtask

    task automatic measure_period(output int p);
        p = 0;
        wait_fs();
        do begin
            tick();
            p++;
        end while (frame_start !== 1'b1 && p < 2000);
    endtask

    int          per;
    logic [1:0]  fc0;
    int          exp_seq [5] = '{1, 2, 3, 0, 1};

    initial begin
        rst = 1'b0; en = 1'b0; mode_sel = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check_val("reset_state", got_vec(), 64'({1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}));

        // Mode A steady state and its frame period.
        rst = 1'b1; en = 1'b1;
        measure_period(per);
        check_val("period_A", 64'(per), 64'(450));

        // Request B mid-frame; it must appear only at the next (0,0).
        run_to_pix(150);
        mode_sel = 1'b1;
        run_to_pix(449);
        check_val("no_early_switch", 64'(mode_active), 64'(0));
        wait_fs();
        check_val("switch_B", 64'({mode_active, hcount, vcount}), 64'({1'b1, 11'd0, 11'd0}));
        measure_period(per);
        check_val("period_B", 64'(per), 64'(288));

        // Back to A, then a request pulse withdrawn before the frame ends.
        mode_sel = 1'b0;
        wait_fs();
        check_val("switch_A", 64'(mode_active), 64'(0));
        run_to_pix(100);
        mode_sel = 1'b1;
        repeat (200) tick();
        mode_sel = 1'b0;
        wait_fs();
        check_val("pulse_no_switch", 64'(mode_active), 64'(0));

        // Stall exactly on the end-of-frame cycle.
        run_to_pix(449);
        fc0 = frame_cnt;
        en = 1'b0;
        repeat (50) tick();
        check_val("freeze", 64'({hcount, vcount, frame_start, frame_cnt}),
                  64'({11'd29, 11'd14, 1'b0, fc0}));
        en = 1'b1;
        tick();
        check_val("resume", 64'({hcount, vcount, frame_start, frame_cnt}),
                  64'({11'd0, 11'd0, 1'b1, 2'(fc0 + 2'd1)}));

        // Mid-frame reset while generating B.
        mode_sel = 1'b1;
        wait_fs();
        run_to_pix(5 * 24 + 10);
        mode_sel = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_val("mid_reset", 64'({mode_active, hcount, vcount, hsync, vsync, frame_start, frame_cnt}),
                  64'({1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 2'd0}));

        // Two-bit frame counter wraps.
        for (int i = 0; i < 5; i++) begin
            wait_fs();
            check_val($sformatf("frame_cnt_seq%0d", i), 64'(frame_cnt), 64'(exp_seq[i]));
        end

        // Randomised enables, mode requests and occasional resets.
        for (int i = 0; i < 30000; i++) begin
            en  = ($urandom % 8) != 0;
            rst = ($urandom % 4000) != 0;
            if ($urandom % 400 == 0) mode_sel = ~mode_sel;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
